mem_arbiter: RTL

- Two-port arbiter that shares the single unified instruction/data memory between the multicycle MIPS core and a DMA/loader requester.
- Sits between the core's memory bus (adr, writedata, memwrite, readdata) and the memory.
- Sequences ownership with a registered grant and round-robin fairness with a burst limit.
- Stalls the non-owner via per-port ready handshakes.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory between the core and a DMA/loader port.
// Define ARB_STATS_EN to add saturating grant/conflict counters.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ready_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_adr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_ready_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_rdata_i,
`ifdef ARB_STATS_EN
  output logic [15:0]   cpu_grants_o,
  output logic [15:0]   dma_grants_o,
  output logic [15:0]   conflicts_o,
`endif
  output logic [1:0]    owner_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA  = 2'b10
  } state_e;

  localparam logic [4:0] MAX_B = 5'(MAX_BURST);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       last_dma_q, last_dma_d;

  logic       own_req, oth_req;
  state_e     other_st;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      burst_q    <= 4'd0;
      last_dma_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      last_dma_q <= last_dma_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    last_dma_d = last_dma_q;
    own_req    = (state_q == ST_CPU) ? cpu_req_i : dma_req_i;
    oth_req    = (state_q == ST_CPU) ? dma_req_i : cpu_req_i;
    other_st   = (state_q == ST_CPU) ? ST_DMA : ST_CPU;
    case (state_q)
      ST_IDLE: begin
        burst_d = 4'd0;
        if (cpu_req_i && dma_req_i) state_d = last_dma_q ? ST_CPU : ST_DMA;
        else if (cpu_req_i)         state_d = ST_CPU;
        else if (dma_req_i)         state_d = ST_DMA;
      end
      ST_CPU, ST_DMA: begin
        if (own_req) begin
          // >= rather than == so a count saturated while the other port was idle still hands over.
          if (oth_req && ({1'b0, burst_q} + 5'd1 >= MAX_B)) begin
            state_d    = other_st;
            burst_d    = 4'd0;
            last_dma_d = (state_q == ST_DMA);
          end else if ({1'b0, burst_q} < MAX_B) begin
            burst_d = burst_q + 4'd1;
          end
        end else begin
          burst_d = 4'd0;
          state_d = oth_req ? other_st : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = 4'd0;
      end
    endcase
  end

  // Datapath mux follows the registered owner; a non-owner sees no ready and zero data.
  always_comb begin
    mem_adr_o   = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    cpu_rdata_o = '0;
    dma_rdata_o = '0;
    cpu_ready_o = 1'b0;
    dma_ready_o = 1'b0;
    case (state_q)
      ST_CPU: begin
        mem_adr_o   = cpu_adr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_we_o    = cpu_req_i & cpu_we_i;
        cpu_ready_o = cpu_req_i;
        cpu_rdata_o = mem_rdata_i;
      end
      ST_DMA: begin
        mem_adr_o   = dma_adr_i;
        mem_wdata_o = dma_wdata_i;
        mem_we_o    = dma_req_i & dma_we_i;
        dma_ready_o = dma_req_i;
        dma_rdata_o = mem_rdata_i;
      end
      default: ;
    endcase
  end

  assign owner_o = state_q;

`ifdef ARB_STATS_EN
  logic [2:0] stat_inc;

  assign stat_inc[0] = cpu_ready_o;
  assign stat_inc[1] = dma_ready_o;
  assign stat_inc[2] = (cpu_req_i && state_q != ST_CPU) || (dma_req_i && state_q != ST_DMA);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                               cnt_q <= 16'd0;
        else if (stat_inc[gi] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
    end
  endgenerate

  assign cpu_grants_o = g_stat[0].cnt_q;
  assign dma_grants_o = g_stat[1].cnt_q;
  assign conflicts_o  = g_stat[2].cnt_q;
`endif

endmodule
